// File: rtl/instr_mem_if.sv
// Bus between the instruction memory controller and its users: the program loader
// and the IF-stage fetch path. Only clk and reset are kept outside.
interface instr_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              start;
  logic              prog_err;
  logic              mem_ready;
  logic              fetch_req;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              fault_misalign;
  logic              fault_range;

  modport master (
    output prog_we, prog_addr, prog_data, start, fetch_req, pc,
    input  prog_err, mem_ready, instr, instr_valid, fault_misalign, fault_range
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, fetch_req, pc,
    output prog_err, mem_ready, instr, instr_valid, fault_misalign, fault_range
  );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Word-addressed instruction memory. It zero-fills after reset, takes a program image,
// then serves registered fetches; illegal fetches return a NOP and raise fault flags.
//
//   state | meaning
//   CLEAR | writing zeros, one word per cycle, DEPTH cycles
//   LOAD  | accepting program writes, waiting for start
//   RUN   | serving fetches, mem_ready high
module instr_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input logic        clk,
  input logic        reset,
  instr_mem_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-3:0] DEPTH_L  = (ADDR_W-2)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-3:0] prog_word;
  logic [ADDR_W-3:0] pc_word;
  logic              prog_legal;
  logic              pc_misalign;
  logic              pc_range;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;

  assign prog_word   = bus.prog_addr[ADDR_W-1:2];
  assign pc_word     = bus.pc[ADDR_W-1:2];
  assign prog_legal  = (bus.prog_addr[1:0] == 2'b00) && (prog_word < DEPTH_L);
  assign pc_misalign = (bus.pc[1:0] != 2'b00);
  assign pc_range    = (pc_word >= DEPTH_L);

  // Single write port shared by the zero-fill sweep and the program loader.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = clr_cnt;
    mem_wdata = '0;
    if (!reset) begin
      case (state)
        CLEAR: mem_we = 1'b1;
        LOAD: begin
          if (bus.prog_we && prog_legal) begin
            mem_we    = 1'b1;
            mem_idx   = prog_word[IDX_W-1:0];
            mem_wdata = bus.prog_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= CLEAR;
      clr_cnt            <= '0;
      bus.prog_err       <= 1'b0;
      bus.mem_ready      <= 1'b0;
      bus.instr_valid    <= 1'b0;
      bus.fault_misalign <= 1'b0;
      bus.fault_range    <= 1'b0;
      bus.instr          <= '0;
    end else begin
      // Any write outside LOAD, or to an illegal address, is rejected.
      bus.prog_err       <= bus.prog_we && !((state == LOAD) && prog_legal);
      bus.instr_valid    <= 1'b0;
      bus.fault_misalign <= 1'b0;
      bus.fault_range    <= 1'b0;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_IDX) state <= LOAD;
        end
        LOAD: begin
          if (bus.start) begin
            state         <= RUN;
            bus.mem_ready <= 1'b1;
          end
        end
        RUN: begin
          bus.mem_ready <= 1'b1;
          if (bus.fetch_req) begin
            bus.instr_valid    <= 1'b1;
            bus.fault_misalign <= pc_misalign;
            bus.fault_range    <= pc_range;
            bus.instr          <= (pc_misalign || pc_range) ? '0 : mem[pc_word[IDX_W-1:0]];
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule
